// File: rtl/decode_out_capture_fifo.sv
// Capture FIFO for decode-stage outputs: qualifies, filters, sequence-tags and buffers samples.
// Optional macro DECODE_OUT_CAP_TIMESTAMP_EN adds a 32-bit push timestamp per entry.
module decode_out_capture_fifo #(
   parameter int DATA_W = 16,
   parameter int ECTL_W = 6,
   parameter int WCTL_W = 2,
   parameter int DEPTH  = 8,
   parameter int SEQ_W  = 8,
   parameter int DROP_W = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       enable_decode,
   input  logic [ECTL_W-1:0]          E_Control,
   input  logic                       Mem_Control,
   input  logic [WCTL_W-1:0]          W_Control,
   input  logic [DATA_W-1:0]          IR,
   input  logic [DATA_W-1:0]          npc_out,
   input  logic                       capture_en,
   input  logic                       filter_dup,
   input  logic                       clear,
   output logic                       txn_valid,
   input  logic                       txn_ready,
   output logic [ECTL_W-1:0]          txn_E_Control,
   output logic                       txn_Mem_Control,
   output logic [WCTL_W-1:0]          txn_W_Control,
   output logic [DATA_W-1:0]          txn_IR,
   output logic [DATA_W-1:0]          txn_npc_out,
   output logic [SEQ_W-1:0]           txn_seq,
`ifdef DECODE_OUT_CAP_TIMESTAMP_EN
   output logic [31:0]                txn_timestamp,
`endif
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       full,
   output logic [DROP_W-1:0]          drop_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef struct packed {
`ifdef DECODE_OUT_CAP_TIMESTAMP_EN
      logic [31:0]       ts;
`endif
      logic [SEQ_W-1:0]  seq;
      logic [ECTL_W-1:0] ectl;
      logic              mctl;
      logic [WCTL_W-1:0] wctl;
      logic [DATA_W-1:0] ir;
      logic [DATA_W-1:0] npc;
   } entry_t;

   entry_t            mem [DEPTH];
   entry_t            entry_in;
   entry_t            head;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [SEQ_W-1:0]  seq;

   logic              hist_valid;
   logic [ECTL_W-1:0] hist_ectl;
   logic              hist_mctl;
   logic [WCTL_W-1:0] hist_wctl;
   logic [DATA_W-1:0] hist_ir;
   logic [DATA_W-1:0] hist_npc;

   logic candidate;
   logic is_dup;
   logic accept;
   logic pop;
   logic push_ok;
   logic drop;

`ifdef DECODE_OUT_CAP_TIMESTAMP_EN
   logic [31:0] cycle_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)     cycle_cnt <= '0;
      else if (clear) cycle_cnt <= '0;
      else            cycle_cnt <= cycle_cnt + 32'd1;
   end
`endif

   // Handshake: an entry transfers on any edge where txn_valid && txn_ready;
   // txn_valid never depends on txn_ready and head data holds until that edge.
   assign txn_valid  = (count != '0);
   assign full       = (count == DEPTH_C);
   assign fifo_count = count;

   assign candidate = enable_decode && capture_en;
   assign is_dup    = filter_dup && hist_valid &&
                      (E_Control == hist_ectl) && (Mem_Control == hist_mctl) &&
                      (W_Control == hist_wctl) && (IR == hist_ir) && (npc_out == hist_npc);
   assign accept    = candidate && !is_dup;
   assign pop       = txn_valid && txn_ready;
   // A full FIFO still takes a push when the head leaves on the same edge.
   assign push_ok   = accept && (!full || pop);
   assign drop      = accept && full && !pop;

   always_comb begin
      entry_in      = '0;
      entry_in.seq  = seq;
      entry_in.ectl = E_Control;
      entry_in.mctl = Mem_Control;
      entry_in.wctl = W_Control;
      entry_in.ir   = IR;
      entry_in.npc  = npc_out;
`ifdef DECODE_OUT_CAP_TIMESTAMP_EN
      entry_in.ts   = cycle_cnt;
`endif
   end

   // Storage is reset so the head reads as zero straight out of reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (!clear && push_ok) begin
         mem[wr_ptr] <= entry_in;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         seq    <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         seq    <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
            seq    <= seq + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                            drop_cnt <= '0;
      else if (clear)                        drop_cnt <= '0;
      else if (drop && (drop_cnt != '1))     drop_cnt <= drop_cnt + 1'b1;
   end

   // History follows every accepted sample, including ones lost to a full FIFO.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hist_valid <= 1'b0;
         hist_ectl  <= '0;
         hist_mctl  <= 1'b0;
         hist_wctl  <= '0;
         hist_ir    <= '0;
         hist_npc   <= '0;
      end else if (clear) begin
         hist_valid <= 1'b0;
      end else if (accept) begin
         hist_valid <= 1'b1;
         hist_ectl  <= E_Control;
         hist_mctl  <= Mem_Control;
         hist_wctl  <= W_Control;
         hist_ir    <= IR;
         hist_npc   <= npc_out;
      end
   end

   assign head            = mem[rd_ptr];
   assign txn_E_Control   = head.ectl;
   assign txn_Mem_Control = head.mctl;
   assign txn_W_Control   = head.wctl;
   assign txn_IR          = head.ir;
   assign txn_npc_out     = head.npc;
   assign txn_seq         = head.seq;
`ifdef DECODE_OUT_CAP_TIMESTAMP_EN
   assign txn_timestamp   = head.ts;
`endif

endmodule

// File: tb/tb_decode_out_capture_fifo.sv
// Directed bench for decode_out_capture_fifo: reset, capture, full/drop, filter, clear, async reset.
module tb_decode_out_capture_fifo;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable_decode;
   logic [5:0]  E_Control;
   logic        Mem_Control;
   logic [1:0]  W_Control;
   logic [15:0] IR;
   logic [15:0] npc_out;
   logic        capture_en;
   logic        filter_dup;
   logic        clear;
   logic        txn_valid;
   logic        txn_ready;
   logic [5:0]  txn_E_Control;
   logic        txn_Mem_Control;
   logic [1:0]  txn_W_Control;
   logic [15:0] txn_IR;
   logic [15:0] txn_npc_out;
   logic [7:0]  txn_seq;
`ifdef DECODE_OUT_CAP_TIMESTAMP_EN
   logic [31:0] txn_timestamp;
`endif
   logic [3:0]  fifo_count;
   logic        full;
   logic [15:0] drop_cnt;

   int total = 0;
   int bad   = 0;

   decode_out_capture_fifo dut (
      .clock(clock), .reset(reset), .enable_decode(enable_decode),
      .E_Control(E_Control), .Mem_Control(Mem_Control), .W_Control(W_Control),
      .IR(IR), .npc_out(npc_out), .capture_en(capture_en), .filter_dup(filter_dup),
      .clear(clear), .txn_valid(txn_valid), .txn_ready(txn_ready),
      .txn_E_Control(txn_E_Control), .txn_Mem_Control(txn_Mem_Control),
      .txn_W_Control(txn_W_Control), .txn_IR(txn_IR), .txn_npc_out(txn_npc_out),
      .txn_seq(txn_seq),
`ifdef DECODE_OUT_CAP_TIMESTAMP_EN
      .txn_timestamp(txn_timestamp),
`endif
      .fifo_count(fifo_count), .full(full), .drop_cnt(drop_cnt)
   );

   always #5 clock = ~clock;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_sample(input logic [15:0] ir, input logic [15:0] npc);
      IR = ir;
      npc_out = npc;
      enable_decode = 1'b1;
      step();
      enable_decode = 1'b0;
   endtask

   task automatic pop_one();
      txn_ready = 1'b1;
      step();
      txn_ready = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      enable_decode = 1'b0; E_Control = 6'h0; Mem_Control = 1'b0; W_Control = 2'h0;
      IR = 16'h0; npc_out = 16'h0; capture_en = 1'b1; filter_dup = 1'b0;
      clear = 1'b0; txn_ready = 1'b0;
      step(); step();
      total++; if (txn_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", txn_valid); end
      total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b want=0", full); end
      total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
      total++; if ({txn_IR, txn_npc_out, txn_seq} !== 40'd0) begin bad++; $display("FAIL reset_data got=%h want=0", {txn_IR, txn_npc_out, txn_seq}); end
      reset = 1'b1;
      step();
   endtask

   task automatic test_first_push();
      E_Control = 6'h2A; Mem_Control = 1'b1; W_Control = 2'h2;
      push_sample(16'h1234, 16'h3001);
      total++; if (txn_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%0b want=1", txn_valid); end
      total++; if (txn_IR !== 16'h1234) begin bad++; $display("FAIL first_ir got=%h want=1234", txn_IR); end
      total++; if (txn_npc_out !== 16'h3001) begin bad++; $display("FAIL first_npc got=%h want=3001", txn_npc_out); end
      total++; if ({txn_E_Control, txn_Mem_Control, txn_W_Control} !== {6'h2A, 1'b1, 2'h2}) begin bad++; $display("FAIL first_ctl got=%h want=%h", {txn_E_Control, txn_Mem_Control, txn_W_Control}, {6'h2A, 1'b1, 2'h2}); end
      total++; if (txn_seq !== 8'd0) begin bad++; $display("FAIL first_seq got=%0d want=0", txn_seq); end
      total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL first_count got=%0d want=1", fifo_count); end
      step();
      total++; if (txn_IR !== 16'h1234 || txn_valid !== 1'b1) begin bad++; $display("FAIL first_hold ir=%h valid=%0b want 1234/1", txn_IR, txn_valid); end
      pop_one();
      total++; if (txn_valid !== 1'b0 || fifo_count !== 4'd0) begin bad++; $display("FAIL first_pop valid=%0b count=%0d want 0/0", txn_valid, fifo_count); end
      E_Control = 6'h0; Mem_Control = 1'b0; W_Control = 2'h0;
   endtask

   task automatic test_full_drop();
      do_clear();
      for (int i = 0; i < 11; i++) push_sample(16'h0100 + 16'(i), 16'h4000 + 16'(i));
      total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag got=%0b want=1", full); end
      total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d want=8", fifo_count); end
      total++; if (drop_cnt !== 16'd3) begin bad++; $display("FAIL full_drop got=%0d want=3", drop_cnt); end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (txn_valid !== 1'b1 || txn_seq !== 8'(i) || txn_IR !== 16'h0100 + 16'(i)) begin
            bad++; $display("FAIL drain_%0d valid=%0b seq=%0d ir=%h want 1/%0d/%h", i, txn_valid, txn_seq, txn_IR, i, 16'h0100 + 16'(i));
         end
         pop_one();
      end
      total++; if (txn_valid !== 1'b0 || fifo_count !== 4'd0 || full !== 1'b0) begin bad++; $display("FAIL drain_empty valid=%0b count=%0d full=%0b want 0/0/0", txn_valid, fifo_count, full); end
   endtask

   task automatic test_full_push_pop();
      do_clear();
      total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL clear_drop got=%0d want=0", drop_cnt); end
      for (int i = 0; i < 8; i++) push_sample(16'h0200 + 16'(i), 16'h5000);
      txn_ready = 1'b1;
      push_sample(16'h02FF, 16'h5000);
      txn_ready = 1'b0;
      total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL pp_count got=%0d want=8", fifo_count); end
      total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL pp_drop got=%0d want=0", drop_cnt); end
      total++; if (txn_seq !== 8'd1 || txn_IR !== 16'h0201) begin bad++; $display("FAIL pp_head seq=%0d ir=%h want 1/0201", txn_seq, txn_IR); end
      for (int i = 0; i < 7; i++) pop_one();
      total++; if (txn_seq !== 8'd8 || txn_IR !== 16'h02FF || fifo_count !== 4'd1) begin bad++; $display("FAIL pp_last seq=%0d ir=%h count=%0d want 8/02ff/1", txn_seq, txn_IR, fifo_count); end
      pop_one();
   endtask

   task automatic test_filter();
      do_clear();
      filter_dup = 1'b1;
      for (int i = 0; i < 4; i++) push_sample(16'h5020, 16'h6000);
      push_sample(16'h5021, 16'h6000);
      total++; if (fifo_count !== 4'd2) begin bad++; $display("FAIL filt_on_count got=%0d want=2", fifo_count); end
      total++; if (txn_seq !== 8'd0 || txn_IR !== 16'h5020) begin bad++; $display("FAIL filt_on_e0 seq=%0d ir=%h want 0/5020", txn_seq, txn_IR); end
      pop_one();
      total++; if (txn_seq !== 8'd1 || txn_IR !== 16'h5021) begin bad++; $display("FAIL filt_on_e1 seq=%0d ir=%h want 1/5021", txn_seq, txn_IR); end
      pop_one();
      do_clear();
      filter_dup = 1'b0;
      for (int i = 0; i < 4; i++) push_sample(16'h5020, 16'h6000);
      push_sample(16'h5021, 16'h6000);
      total++; if (fifo_count !== 4'd5) begin bad++; $display("FAIL filt_off_count got=%0d want=5", fifo_count); end
      for (int i = 0; i < 4; i++) pop_one();
      total++; if (txn_seq !== 8'd4 || txn_IR !== 16'h5021) begin bad++; $display("FAIL filt_off_last seq=%0d ir=%h want 4/5021", txn_seq, txn_IR); end
      pop_one();
   endtask

   task automatic test_clear();
      do_clear();
      for (int i = 0; i < 4; i++) push_sample(16'h0700 + 16'(i), 16'h7000);
      clear = 1'b1;
      txn_ready = 1'b1;
      push_sample(16'h07AA, 16'h7000);
      clear = 1'b0;
      txn_ready = 1'b0;
      total++; if (fifo_count !== 4'd0 || txn_valid !== 1'b0 || drop_cnt !== 16'd0) begin bad++; $display("FAIL clear_state count=%0d valid=%0b drop=%0d want 0/0/0", fifo_count, txn_valid, drop_cnt); end
      push_sample(16'h07BB, 16'h7000);
      total++; if (txn_seq !== 8'd0 || txn_IR !== 16'h07BB || fifo_count !== 4'd1) begin bad++; $display("FAIL clear_next seq=%0d ir=%h count=%0d want 0/07bb/1", txn_seq, txn_IR, fifo_count); end
      pop_one();
   endtask

   task automatic test_reset_mid();
      do_clear();
      for (int i = 0; i < 9; i++) push_sample(16'h0900 + 16'(i), 16'h9000);
      total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL mid_pre_drop got=%0d want=1", drop_cnt); end
      txn_ready = 1'b1;
      step(); step();
      #2;
      reset = 1'b0;
      #1;
      total++; if (txn_valid !== 1'b0 || fifo_count !== 4'd0 || drop_cnt !== 16'd0 || full !== 1'b0) begin bad++; $display("FAIL mid_reset valid=%0b count=%0d drop=%0d full=%0b want 0/0/0/0", txn_valid, fifo_count, drop_cnt, full); end
      txn_ready = 1'b0;
      step();
      reset = 1'b1;
      step();
      push_sample(16'h0A00, 16'hA000);
      total++; if (txn_seq !== 8'd0 || fifo_count !== 4'd1) begin bad++; $display("FAIL mid_after seq=%0d count=%0d want 0/1", txn_seq, fifo_count); end
   endtask

   initial begin
      test_reset();
      test_first_push();
      test_full_drop();
      test_full_push_pop();
      test_filter();
      test_clear();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_out_capture_fifo.md
Name: decode_out_capture_fifo

Overview:
- Synthesizable, parametrised capture engine for decode-stage outputs: E_Control, Mem_Control, W_Control, IR, npc_out.
- Qualifies each clock sample with enable_decode and an optional duplicate filter, tags it with a sequence number and buffers it in a FIFO.
- Drains through a valid/ready port.
- Sits beside the decode stage as the hardware successor of the decode_out monitor path; adds buffering, back-pressure, drop accounting and filtering.

Parameters:
- DATA_W, 16, width of IR and npc_out.
- ECTL_W, 6, width of E_Control.
- WCTL_W, 2, width of W_Control.
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- SEQ_W, 8, sequence-tag width.
- DROP_W, 16, drop-counter width.

Ports:
- clock  in  1  sole clock; all flops on posedge.
- reset  in  1  asynchronous, active-low reset.
- enable_decode  in  1  sample qualifier.
- E_Control  in  ECTL_W  decode execute controls.
- Mem_Control  in  1  decode memory control.
- W_Control  in  WCTL_W  decode writeback controls.
- IR  in  DATA_W  instruction register.
- npc_out  in  DATA_W  next PC.
- capture_en  in  1  global capture gate.
- filter_dup  in  1  suppress samples identical to the last captured one.
- clear  in  1  synchronous flush of FIFO, counters and filter history.
- txn_valid  out  1  head entry available.
- txn_ready  in  1  consumer accepts head.
- txn_E_Control  out  ECTL_W  head field.
- txn_Mem_Control  out  1  head field.
- txn_W_Control  out  WCTL_W  head field.
- txn_IR  out  DATA_W  head field.
- txn_npc_out  out  DATA_W  head field.
- txn_seq  out  SEQ_W  sequence tag of head.
- fifo_count  out  $clog2(DEPTH+1)  occupancy.
- full  out  1  fifo_count==DEPTH.
- drop_cnt  out  DROP_W  saturating count of samples lost to full.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty; txn_valid=0; all txn_* data=0; fifo_count=0; full=0; drop_cnt=0; seq counter=0; filter history invalid.
- Candidate sample: enable_decode && capture_en at a posedge. Fields are taken from the inputs at that edge.
- Duplicate filter: when filter_dup=1, a candidate is suppressed if history is valid and all five fields equal the history. Suppressed samples are neither counted nor sequenced.
- Accepted candidate:
  - Becomes a push.
  - History is updated with every accepted candidate, including ones dropped for full.
  - The seq counter increments, mod 2^SEQ_W, only on successful push.
  - Each entry stores the current seq value.
- Pop: txn_valid && txn_ready at a posedge.
- Latency: a push into an empty FIFO gives txn_valid=1 on the next cycle. There is no same-cycle bypass.
- txn_* outputs present the head entry directly and stay stable while txn_valid=1 and txn_ready=0. Data is don't-care when txn_valid=0 after the first pop, and 0 out of reset.
- Full with push and no pop: push discarded; drop_cnt increments and saturates at all-ones; seq not incremented.
- Full with simultaneous push and pop: both succeed; count stays DEPTH; no drop.
- Empty with pop requested: impossible, since txn_valid=0.
- Push and pop in the same cycle at any other occupancy: count unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally. full/fifo_count are derived from a separate occupancy counter.
- clear=1 at a posedge:
  - Same reset state as above, except the txn_* data registers need not be zeroed.
  - clear takes priority over a same-cycle push and pop; both are ignored.
- capture_en or filter_dup changing mid-stream takes effect on the same edge it is sampled. filter_dup has no effect on history updating.
- Reset asserted mid-transfer: all state is lost immediately. A consumer must treat txn_valid falling without a handshake as an abort.

Optional Feature:
- Macro DECODE_OUT_CAP_TIMESTAMP_EN.
- When defined:
  - Adds a 32-bit free-running cycle counter, reset to 0 and cleared by clear, wrapping at 2^32.
  - Adds output port txn_timestamp[31:0], holding the counter value at the edge the entry was pushed.
  - Each FIFO entry widens by 32 bits.
- When undefined: no counter, no port, no storage.

Test Plan:
- Reset release, enable_decode=1, capture_en=1, IR=16'h1234, npc_out=16'h3001, one cycle, txn_ready=0 -> next cycle txn_valid=1, txn_IR=16'h1234, txn_npc_out=16'h3001, txn_seq=0, fifo_count=1.
- Push 8 distinct samples with txn_ready=0, then 3 more -> full=1, fifo_count=8, drop_cnt=3. Then drain -> txn_seq 0..7 in order.
- FIFO full, push and txn_ready=1 on the same cycle -> fifo_count stays 8, drop_cnt unchanged, new entry appears as last with seq=8.
- filter_dup=1, IR=16'h5020 repeated 4 cycles, then 16'h5021 -> exactly 2 entries, seq 0 and 1. With filter_dup=0 -> 5 entries.
- 4 entries buffered, clear=1 with a simultaneous push -> next cycle fifo_count=0, txn_valid=0, drop_cnt=0; the next push carries seq=0.
- DECODE_OUT_CAP_TIMESTAMP_EN defined, pushes at cycles 5 and 9 after reset release -> txn_timestamp 5 then 9. Reset asserted mid-drain -> txn_valid=0 and all counters 0 asynchronously.
